// File: rtl/seg_memory.sv
// seg_memory: memory-access stage of the MIPS pipeline.
//
// Holds the execute-stage results in the EX/MEM register, resolves branches
// from that register, performs word loads/stores on an internal 2^NB_DMEM-word
// synchronous data memory and presents a registered MEM/WB bundle to the
// write-back stage. A separate read-only debug port reads memory every cycle.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-low reset
//   i_PC_branch             branch target from execute
//   i_ALU_result            byte address or ALU value
//   i_write_data            store data
//   i_write_register        destination register
//   i_ALU_zero              ALU zero flag
//   i_ctrl_wb_bus           WB controls   [1]=RegWrite [0]=MemtoReg
//   i_ctrl_mem_bus          MEM controls  [2]=Branch [1]=MemRead [0]=MemWrite
//   i_stall                 hold both stage registers, suppress the store
//   i_flush                 load a bubble (zero controls) into EX/MEM
//   i_dbg_addr              debug word address
//   o_PCSrc, o_PC_branch    branch decision and target (from EX/MEM)
//   o_exmem_*               EX/MEM fields used for forwarding
//   o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned
//                           MEM/WB register
//   o_dbg_data              debug read data (one cycle after i_dbg_addr)
//
// There is no handshake on this stage: it advances on every clock edge
// unless i_stall is high, in which case both stage registers hold and the
// store is withheld until the stall lifts.

module seg_memory #(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_DMEM    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [LEN-1:0]        i_PC_branch,
  input  logic [LEN-1:0]        i_ALU_result,
  input  logic [LEN-1:0]        i_write_data,
  input  logic [NB_ADDR-1:0]    i_write_register,
  input  logic                  i_ALU_zero,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [NB_DMEM-1:0]    i_dbg_addr,
  output logic                  o_PCSrc,
  output logic [LEN-1:0]        o_PC_branch,
  output logic [NB_ADDR-1:0]    o_exmem_write_register,
  output logic                  o_exmem_reg_write,
  output logic [LEN-1:0]        o_exmem_ALU_result,
  output logic [LEN-1:0]        o_read_data,
  output logic [LEN-1:0]        o_ALU_result,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic                  o_misaligned,
  output logic [LEN-1:0]        o_dbg_data
);

  localparam int NWORDS = 1 << NB_DMEM;

  // Control-bus bit positions.
  localparam int WB_REG_WRITE  = 1;
  localparam int M_BRANCH      = 2;
  localparam int M_MEM_READ    = 1;
  localparam int M_MEM_WRITE   = 0;

  // ---------------------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------------------
  logic [LEN-1:0]        exmem_pc_branch;
  logic [LEN-1:0]        exmem_alu_result;
  logic [LEN-1:0]        exmem_write_data;
  logic [NB_ADDR-1:0]    exmem_write_register;
  logic                  exmem_zero;
  logic [NB_CTRL_WB-1:0] exmem_ctrl_wb;
  logic [NB_CTRL_M-1:0]  exmem_ctrl_mem;

  // Stall beats flush: a stalled stage keeps its instruction even if the
  // hazard unit also asks for a bubble in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      exmem_pc_branch      <= '0;
      exmem_alu_result     <= '0;
      exmem_write_data     <= '0;
      exmem_write_register <= '0;
      exmem_zero           <= 1'b0;
      exmem_ctrl_wb        <= '0;
      exmem_ctrl_mem       <= '0;
    end else if (!i_stall) begin
      exmem_pc_branch      <= i_PC_branch;
      exmem_alu_result     <= i_ALU_result;
      exmem_write_data     <= i_write_data;
      exmem_write_register <= i_write_register;
      exmem_zero           <= i_ALU_zero;
      if (i_flush) begin
        exmem_ctrl_wb  <= '0;
        exmem_ctrl_mem <= '0;
      end else begin
        exmem_ctrl_wb  <= i_ctrl_wb_bus;
        exmem_ctrl_mem <= i_ctrl_mem_bus;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Branch resolution and forwarding taps
  // ---------------------------------------------------------------------------
  logic branch;
  logic mem_read;
  logic mem_write;

  assign branch    = exmem_ctrl_mem[M_BRANCH];
  assign mem_read  = exmem_ctrl_mem[M_MEM_READ];
  assign mem_write = exmem_ctrl_mem[M_MEM_WRITE];

  assign o_PCSrc                = branch & exmem_zero;
  assign o_PC_branch            = exmem_pc_branch;
  assign o_exmem_write_register = exmem_write_register;
  assign o_exmem_reg_write      = exmem_ctrl_wb[WB_REG_WRITE];
  assign o_exmem_ALU_result     = exmem_alu_result;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // Only the word-index bits are used, so byte addresses wrap modulo the
  // memory size. A non-word-aligned address only matters for memory ops.
  logic [NB_DMEM-1:0] dmem_word;
  logic               misaligned;
  logic               store_en;
  logic               load_en;

  assign dmem_word  = exmem_alu_result[NB_DMEM+1:2];
  assign misaligned = (exmem_alu_result[1:0] != 2'b00) & (mem_read | mem_write);
  assign store_en   = i_rst & ~i_stall & mem_write & ~misaligned;
  assign load_en    = mem_read & ~misaligned;

  // ---------------------------------------------------------------------------
  // Data memory (not reset). All reads use the pre-edge contents, which
  // makes both the load port and the debug port read-first.
  // ---------------------------------------------------------------------------
  logic [LEN-1:0] mem [NWORDS];

  always_ff @(posedge i_clk) begin
    if (store_en) begin
      mem[dmem_word] <= exmem_write_data;
    end
  end

  always_ff @(posedge i_clk) begin
    o_dbg_data <= mem[i_dbg_addr];
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  // A squashed (misaligned) access must not write the register file, so
  // RegWrite is cleared on its way into MEM/WB; MemtoReg passes through.
  logic [NB_CTRL_WB-1:0] memwb_ctrl_wb_next;

  always_comb begin
    memwb_ctrl_wb_next               = exmem_ctrl_wb;
    memwb_ctrl_wb_next[WB_REG_WRITE] = exmem_ctrl_wb[WB_REG_WRITE] & ~misaligned;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_read_data      <= '0;
      o_ALU_result     <= '0;
      o_write_register <= '0;
      o_ctrl_wb_bus    <= '0;
      o_misaligned     <= 1'b0;
    end else if (!i_stall) begin
      o_read_data      <= load_en ? mem[dmem_word] : '0;
      o_ALU_result     <= exmem_alu_result;
      o_write_register <= exmem_write_register;
      o_ctrl_wb_bus    <= memwb_ctrl_wb_next;
      o_misaligned     <= misaligned;
    end
  end

endmodule
